// File: rtl/tank_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tank_pkg
// Purpose  : Shared state/direction encodings and default keycodes for tank_motion.
// Revision : 1.0
// ============================================================================
package tank_pkg;

    typedef enum logic [1:0] {
        ST_ALIVE  = 2'd0,
        ST_DEAD   = 2'd1,
        ST_INVULN = 2'd2,
        ST_OVER   = 2'd3
    } tank_state_t;

    typedef enum logic [1:0] {
        DIR_LEFT  = 2'b00,
        DIR_RIGHT = 2'b01,
        DIR_DOWN  = 2'b10,
        DIR_UP    = 2'b11
    } tank_dir_t;

    localparam logic [7:0] c_key_left  = 8'd80;
    localparam logic [7:0] c_key_right = 8'd79;
    localparam logic [7:0] c_key_down  = 8'd81;
    localparam logic [7:0] c_key_up    = 8'd82;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/frame_countdown.sv
`default_nettype none
// ============================================================================
// Module   : frame_countdown
// Purpose  : Loadable down-counter shared by the respawn and immunity timers.
// Revision : 1.0
// ============================================================================
module frame_countdown #(
    parameter int WIDTH = 7
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] value_i,
    input  logic             enable_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= value_i;
        end else if (enable_i && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign zero_o = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/tank_motion.sv
`default_nettype none
// ============================================================================
// Module   : tank_motion
// Purpose  : Keyboard-driven tank position with lives, respawn and immunity FSM.
// Revision : 1.0
// ============================================================================
module tank_motion
    import tank_pkg::*;
#(
    parameter int unsigned X_CENTER       = 480,
    parameter int unsigned Y_CENTER       = 240,
    parameter int unsigned X_MIN          = 1,
    parameter int unsigned X_MAX          = 639,
    parameter int unsigned Y_MIN          = 1,
    parameter int unsigned Y_MAX          = 479,
    parameter int unsigned STEP           = 1,
    parameter int unsigned SIZE           = 8,
    parameter logic [7:0]  KEY_LEFT       = c_key_left,
    parameter logic [7:0]  KEY_RIGHT      = c_key_right,
    parameter logic [7:0]  KEY_DOWN       = c_key_down,
    parameter logic [7:0]  KEY_UP         = c_key_up,
    parameter int unsigned LIVES          = 3,
    parameter int unsigned RESPAWN_FRAMES = 60,
    parameter int unsigned INVULN_FRAMES  = 120
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [7:0] keycode,
    input  logic       was_hit,
    input  logic [3:0] barrier_collision,
    output logic [9:0] BallX,
    output logic [9:0] BallY,
    output logic [9:0] BallS,
    output logic [1:0] direction,
    output logic       alive,
    output logic       invuln,
    output logic [2:0] lives,
    output logic       game_over
);

    localparam int CW = $clog2(max_u(RESPAWN_FRAMES, INVULN_FRAMES) + 1);

    localparam logic [10:0]   c_x_lo     = 11'(X_MIN + SIZE);
    localparam logic [10:0]   c_x_hi     = 11'(X_MAX - SIZE);
    localparam logic [10:0]   c_y_lo     = 11'(Y_MIN + SIZE);
    localparam logic [10:0]   c_y_hi     = 11'(Y_MAX - SIZE);
    localparam logic [10:0]   c_step     = 11'(STEP);
    localparam logic [9:0]    c_x_center = 10'(X_CENTER);
    localparam logic [9:0]    c_y_center = 10'(Y_CENTER);
    localparam logic [CW-1:0] c_respawn  = CW'(RESPAWN_FRAMES - 1);
    localparam logic [CW-1:0] c_immune   = CW'(INVULN_FRAMES - 1);

    // Extended to 11 bits so a small coordinate minus STEP cannot wrap.
    function automatic logic [9:0] sat_dec(input logic [9:0] v, input logic [10:0] lo);
        logic [10:0] v_ext;
        v_ext = {1'b0, v};
        if (v_ext < (lo + c_step)) return lo[9:0];
        return 10'(v_ext - c_step);
    endfunction

    function automatic logic [9:0] sat_inc(input logic [9:0] v, input logic [10:0] hi);
        logic [10:0] v_sum;
        v_sum = {1'b0, v} + c_step;
        if (v_sum > hi) return hi[9:0];
        return v_sum[9:0];
    endfunction

    tank_state_t state_q;
    tank_dir_t   dir_q,  dir_d;
    logic [9:0]  x_q,    x_d;
    logic [9:0]  y_q,    y_d;
    logic [2:0]  lives_q;

    logic          cd_load;
    logic [CW-1:0] cd_value;
    logic          cd_enable;
    logic          cd_zero;

    always_comb begin
        x_d   = x_q;
        y_d   = y_q;
        dir_d = dir_q;
        case (keycode)
            KEY_LEFT: begin
                dir_d = DIR_LEFT;
                if (!barrier_collision[1]) x_d = sat_dec(x_q, c_x_lo);
            end
            KEY_RIGHT: begin
                dir_d = DIR_RIGHT;
                if (!barrier_collision[0]) x_d = sat_inc(x_q, c_x_hi);
            end
            KEY_DOWN: begin
                dir_d = DIR_DOWN;
                if (!barrier_collision[2]) y_d = sat_inc(y_q, c_y_hi);
            end
            KEY_UP: begin
                dir_d = DIR_UP;
                if (!barrier_collision[3]) y_d = sat_dec(y_q, c_y_lo);
            end
            default: ;
        endcase
    end

    always_comb begin
        cd_load   = 1'b0;
        cd_value  = c_respawn;
        cd_enable = 1'b0;
        case (state_q)
            ST_ALIVE:  cd_load = was_hit;
            ST_DEAD: begin
                cd_load   = cd_zero;
                cd_value  = c_immune;
                cd_enable = 1'b1;
            end
            ST_INVULN: cd_enable = 1'b1;
            default: ;
        endcase
    end

    frame_countdown #(
        .WIDTH (CW)
    ) u_countdown (
        .clk_i    (frame_clk),
        .rst_i    (Reset),
        .load_i   (cd_load),
        .value_i  (cd_value),
        .enable_i (cd_enable),
        .zero_o   (cd_zero)
    );

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state_q <= ST_ALIVE;
            x_q     <= c_x_center;
            y_q     <= c_y_center;
            dir_q   <= DIR_LEFT;
            lives_q <= 3'(LIVES);
        end else begin
            case (state_q)
                ST_ALIVE: begin
                    if (was_hit) begin
                        lives_q <= lives_q - 3'd1;
                        state_q <= (lives_q == 3'd1) ? ST_OVER : ST_DEAD;
                    end else begin
                        x_q   <= x_d;
                        y_q   <= y_d;
                        dir_q <= dir_d;
                    end
                end
                ST_DEAD: begin
                    if (cd_zero) begin
                        x_q     <= c_x_center;
                        y_q     <= c_y_center;
                        dir_q   <= DIR_LEFT;
                        state_q <= ST_INVULN;
                    end
                end
                ST_INVULN: begin
                    x_q   <= x_d;
                    y_q   <= y_d;
                    dir_q <= dir_d;
                    if (cd_zero) state_q <= ST_ALIVE;
                end
                default: ;
            endcase
        end
    end

    assign BallX     = x_q;
    assign BallY     = y_q;
    assign BallS     = 10'(SIZE);
    assign direction = dir_q;
    assign alive     = (state_q == ST_ALIVE) || (state_q == ST_INVULN);
    assign invuln    = (state_q == ST_INVULN);
    assign lives     = lives_q;
    assign game_over = (state_q == ST_OVER);

endmodule
`default_nettype wire

// File: tb/tb_tank_motion.sv
`default_nettype none
// ============================================================================
// Module   : tb_tank_motion
// Purpose  : Directed self-checking bench for tank_motion.
// Revision : 1.0
// ============================================================================
module tb_tank_motion;

    logic       clk = 1'b0;
    logic       Reset;
    logic [7:0] keycode;
    logic       was_hit;
    logic [3:0] barrier;

    logic [9:0] bx, by, bs;
    logic [1:0] dir;
    logic       alive, invuln, over;
    logic [2:0] lives;

    logic [9:0] sx, sy, ss;
    logic [1:0] sdir;
    logic       salive, sinvuln, sover;
    logic [2:0] slives;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    tank_motion dut (
        .frame_clk(clk), .Reset(Reset), .keycode(keycode), .was_hit(was_hit),
        .barrier_collision(barrier), .BallX(bx), .BallY(by), .BallS(bs),
        .direction(dir), .alive(alive), .invuln(invuln), .lives(lives),
        .game_over(over)
    );

    // Coarse step and spawn next to the left wall for the saturation case.
    tank_motion #(.X_CENTER(11), .STEP(4)) dut_s (
        .frame_clk(clk), .Reset(Reset), .keycode(keycode), .was_hit(was_hit),
        .barrier_collision(barrier), .BallX(sx), .BallY(sy), .BallS(ss),
        .direction(sdir), .alive(salive), .invuln(sinvuln), .lives(slives),
        .game_over(sover)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_x"},      bx, 480);
        chk({tag, "_y"},      by, 240);
        chk({tag, "_dir"},    dir, 0);
        chk({tag, "_alive"},  alive, 1);
        chk({tag, "_invuln"}, invuln, 0);
        chk({tag, "_lives"},  lives, 3);
        chk({tag, "_over"},   over, 0);
    endtask

    task automatic hit_and_recover(input int exp_lives);
        was_hit = 1'b1;
        step();
        was_hit = 1'b0;
        chk("gameover_hit_lives", lives, exp_lives);
        chk("gameover_hit_dead", alive, 0);
        repeat (180) step();
        chk("gameover_recovered_alive", alive, 1);
        chk("gameover_recovered_invuln", invuln, 0);
    endtask

    initial begin
        Reset   = 1'b1;
        keycode = 8'd0;
        was_hit = 1'b0;
        barrier = 4'b0000;
        step();
        step();
        chk_reset_state("reset");
        chk("reset_size", bs, 8);
        chk("reset_s_x", sx, 11);
        Reset = 1'b0;

        // Saturation at the left bound: max(11-4, 1+8) = 9
        keycode = 8'd80;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("sat_x", sx, 9);
            chk("sat_dir", sdir, 0);
            chk("left_x", bx, 479 - i);
        end
        repeat (177) step();
        chk("left_x_300", bx, 300);

        // Blocked turn: direction changes, position does not
        keycode = 8'd79;
        barrier = 4'b0001;
        step();
        chk("blocked_x", bx, 300);
        chk("blocked_dir", dir, 1);

        keycode = 8'h04;
        barrier = 4'b0000;
        step();
        chk("otherkey_x", bx, 300);
        chk("otherkey_dir", dir, 1);

        keycode = 8'd82;
        step();
        chk("up_y", by, 239);
        chk("up_dir", dir, 3);

        keycode = 8'd81;
        barrier = 4'b0100;
        step();
        chk("down_blocked_y", by, 239);
        chk("down_blocked_dir", dir, 2);
        barrier = 4'b0000;

        // Hit and simultaneous up key: hit wins
        keycode = 8'd82;
        was_hit = 1'b1;
        step();
        chk("simul_y", by, 239);
        chk("simul_alive", alive, 0);
        chk("simul_lives", lives, 2);
        was_hit = 1'b0;
        keycode = 8'd80;
        for (int i = 0; i < 59; i++) begin
            step();
            chk("dead_alive", alive, 0);
            chk("dead_x_held", bx, 300);
        end
        keycode = 8'd0;
        step();
        chk("respawn_alive", alive, 1);
        chk("respawn_invuln", invuln, 1);
        chk("respawn_x", bx, 480);
        chk("respawn_y", by, 240);
        chk("respawn_dir", dir, 0);
        chk("respawn_lives", lives, 2);

        // Hits ignored, movement allowed while immune
        was_hit = 1'b1;
        step();
        was_hit = 1'b0;
        chk("invuln_hit_lives", lives, 2);
        chk("invuln_hit_invuln", invuln, 1);
        keycode = 8'd79;
        repeat (5) step();
        chk("invuln_move_x", bx, 485);
        keycode = 8'd0;
        repeat (113) step();
        chk("invuln_last_frame", invuln, 1);
        step();
        chk("invuln_end_invuln", invuln, 0);
        chk("invuln_end_alive", alive, 1);

        // Reset while DEAD with countdown at 30
        was_hit = 1'b1;
        step();
        was_hit = 1'b0;
        chk("mid_hit_lives", lives, 1);
        repeat (29) step();
        chk("mid_dead_alive", alive, 0);
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        chk_reset_state("mid_reset");

        // Three hits to game over
        hit_and_recover(2);
        hit_and_recover(1);
        was_hit = 1'b1;
        step();
        was_hit = 1'b0;
        chk("over_flag", over, 1);
        chk("over_alive", alive, 0);
        chk("over_lives", lives, 0);
        keycode = 8'd79;
        repeat (5) step();
        chk("over_x_held", bx, 480);
        chk("over_still", over, 1);
        keycode = 8'd0;
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        chk_reset_state("over_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tank_motion.md
TANK_MOTION -- requirements
Module: tank_motion

Interface
REQ-001 Parameters SHALL be, as name, default, meaning:
- X_CENTER 480: spawn X
- Y_CENTER 240: spawn Y
- X_MIN 1, X_MAX 639, Y_MIN 1, Y_MAX 479: playfield bounds
- STEP 1: pixels moved per frame
- SIZE 8: tank half-size
- KEY_LEFT 80, KEY_RIGHT 79, KEY_DOWN 81, KEY_UP 82: keycodes
- LIVES 3: lives at reset, 1..7
- RESPAWN_FRAMES 60: dead time
- INVULN_FRAMES 120: post-spawn immunity
REQ-002 Ports SHALL be, as name, direction, width, meaning:
- frame_clk in 1: the one clock
- Reset in 1: synchronous, active-high reset
- keycode in 8: current key
- was_hit in 1: projectile hit this frame
- barrier_collision in 4: blocked flags, [0] right, [1] left, [2] down, [3] up
- BallX out 10, BallY out 10: tank centre
- BallS out 10: constant SIZE
- direction out 2: facing, 00 L, 01 R, 10 D, 11 U
- alive out 1: tank drawable and controllable
- invuln out 1: hits ignored
- lives out 3: lives remaining
- game_over out 1: no lives left

Function
REQ-003 The block SHALL use a state machine with states ALIVE, DEAD, INVULN and OVER; all state changes SHALL occur on frame_clk.
REQ-004 In ALIVE or INVULN, a keycode equal to a KEY_* parameter SHALL move the tank one STEP in that direction in the same clock edge, with no motion register and no one-frame lag.
REQ-005 Movement SHALL be suppressed when the matching barrier_collision bit is 1.
REQ-006 Movement SHALL saturate at the bounds:
- Left: X = max(X-STEP, X_MIN+SIZE)
- Right: X = min(X+STEP, X_MAX-SIZE)
- Y uses the same rules with Y_MIN and Y_MAX.
REQ-007 Bound arithmetic SHALL be computed 11 bits wide so that X-STEP never wraps below zero.
REQ-008 direction SHALL update on any matching key, even when movement is blocked or saturated; any other keycode SHALL cause no movement and no direction change.
REQ-009 In ALIVE, was_hit=1 SHALL have priority over movement:
- the position does not change
- lives decrements by 1
- the next state is DEAD, or OVER if lives was 1
- the countdown loads RESPAWN_FRAMES-1.
REQ-010 In DEAD:
- alive=0 and the position is held
- keys and was_hit are ignored
- the countdown decrements each frame.
REQ-011 When the countdown reaches 0 in DEAD, the block SHALL set position to (X_CENTER, Y_CENTER), set direction=00, enter INVULN and load INVULN_FRAMES-1.
REQ-012 In INVULN:
- invuln=1 and alive=1
- movement is allowed and was_hit is ignored
- at countdown 0 the next state is ALIVE.
REQ-013 In OVER, the block SHALL set game_over=1, alive=0 and lives=0, hold the position, and leave OVER only on Reset.
REQ-014 The countdown width SHALL be $clog2(max(RESPAWN_FRAMES, INVULN_FRAMES)+1).
REQ-015 All outputs SHALL be registered or decoded directly from the state; no input SHALL pass combinationally to any output.

Reset
REQ-016 Reset=1 at a frame_clk edge SHALL override every other input in every state, including mid-countdown and OVER.
REQ-017 After reset the outputs SHALL be:
- state ALIVE, countdown 0
- BallX=X_CENTER, BallY=Y_CENTER, direction=00
- alive=1, invuln=0, lives=LIVES, game_over=0.

Structure
REQ-018 A shared package tank_pkg SHALL hold the state enum, the direction enum (DIR_LEFT, DIR_RIGHT, DIR_DOWN, DIR_UP) and the default keycode constants.
REQ-019 The dead and invuln timers SHALL be one sub-module, frame_countdown (load, value, enable, zero flag), shared by DEAD and INVULN.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Saturation: STEP=4, X=11, hold keycode 80 for 3 frames -> X=9, 9, 9; direction=00.
- Blocked turn: X=300, keycode 79, barrier_collision=0001 -> X stays 300, direction=01 on the next edge.
- Hit and respawn: hit in ALIVE, RESPAWN_FRAMES=60, INVULN_FRAMES=120 -> lives 3->2, alive=0 for 60 frames, then position (480,240) with invuln=1; a hit during INVULN leaves lives=2; ALIVE after 120 frames.
- Game over: three separate hits with LIVES=3 -> state OVER, game_over=1, alive=0; keys do not move the tank; Reset -> lives=3, state ALIVE.
- Simultaneous events: was_hit=1 with keycode 82 in ALIVE -> Y unchanged, state DEAD.
- Mid-countdown reset: Reset at DEAD countdown 30 -> all REQ-017 values on the next edge.
